// File: rtl/dvbc_interleaver_ctrl_if.sv
// Byte-stream and RAM port bundle for the DVB-C interleaver controller.
// master = controller side, slave = surrounding datapath / RAM side.
interface dvbc_interleaver_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        in_data_i;
  logic              in_sync_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [7:0]        out_data_o;
  logic              out_sync_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;

  modport master (
    input  in_data_i, in_sync_i, in_valid_i,
    output in_ready_o,
    output out_data_o, out_sync_o, out_valid_o,
    input  out_ready_i,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport slave (
    output in_data_i, in_sync_i, in_valid_i,
    input  in_ready_o,
    input  out_data_o, out_sync_o, out_valid_o,
    output out_ready_i,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/dvbc_interleaver_ctrl.sv
// Forney interleaver sequencer: sync hunt, branch commutator, per-branch RAM pointers.
// 1-cycle latency through a single output register; a stalled output drops in_ready and freezes RAM access.
module dvbc_interleaver_ctrl #(
  parameter bit SIMULATION = 1'b0,
  parameter bit DEBUG      = 1'b0,
  parameter int I_BRANCH   = 12,
  parameter int M_DEPTH    = 17,
  parameter int ADDR_W     = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  dvbc_interleaver_ctrl_if.master bus,
  output logic                   primed_o,
  output logic                   sync_err_o,
  output logic [1:0]             dbg_state_o
);
  localparam int B_W   = $clog2(I_BRANCH);
  localparam int TOTAL = M_DEPTH * I_BRANCH * (I_BRANCH - 1) / 2;
  localparam int PRIME = I_BRANCH * M_DEPTH * (I_BRANCH - 1);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              in_ready, accept, proc, ram_access;
  logic [B_W-1:0]    b_q, cur_b;
  logic [7:0]        ptr_q [1:I_BRANCH-1];
  logic [7:0]        ptr_cur, lim;
  logic [ADDR_W-1:0] base;
  logic              out_valid_q, out_sync_q, sel_ram_q, sync_err_q;
  logic [7:0]        data_q;
  logic [11:0]       fill_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && accept && bus.in_sync_i) state_d = RUN;
  end

  always_comb begin
    in_ready = (state_q == HUNT) ? 1'b1 : (bus.out_ready_i | ~out_valid_q);
    accept   = bus.in_valid_i & in_ready;
    proc     = accept & ((state_q == RUN) | bus.in_sync_i);
  end

  // A sync byte is always branch 0, whether it locks the stream or is misplaced.
  assign cur_b      = bus.in_sync_i ? '0 : b_q;
  assign ram_access = proc & (cur_b != '0);

  always_comb begin
    base    = '0;
    lim     = '0;
    ptr_cur = '0;
    for (int k = 1; k < I_BRANCH; k++) begin
      if (cur_b == B_W'(k)) begin
        base    = ADDR_W'(M_DEPTH * k * (k - 1) / 2);
        lim     = 8'(M_DEPTH * k - 1);
        ptr_cur = ptr_q[k];
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.ram_en_o    = ram_access;
  assign bus.ram_we_o    = ram_access;
  assign bus.ram_addr_o  = ram_access ? base + ADDR_W'(ptr_cur) : '0;
  assign bus.ram_wdata_o = ram_access ? bus.in_data_i : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sel_ram_q   <= 1'b0;
      data_q      <= '0;
      b_q         <= '0;
      sync_err_q  <= 1'b0;
      fill_q      <= '0;
      for (int k = 1; k < I_BRANCH; k++) ptr_q[k] <= '0;
    end else begin
      sync_err_q <= proc & bus.in_sync_i & (state_q == RUN) & (b_q != '0);
      if (proc) begin
        out_valid_q <= 1'b1;
        out_sync_q  <= bus.in_sync_i;
        sel_ram_q   <= ram_access;
        data_q      <= bus.in_data_i;
        b_q         <= (cur_b == B_W'(I_BRANCH - 1)) ? '0 : cur_b + B_W'(1);
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      // The locking byte itself is the first stream byte counted.
      if (proc && state_q == HUNT)                fill_q <= 12'd1;
      else if (proc && fill_q != 12'(PRIME))       fill_q <= fill_q + 12'd1;
      for (int k = 1; k < I_BRANCH; k++) begin
        if (ram_access && cur_b == B_W'(k))
          ptr_q[k] <= (ptr_cur == lim) ? '0 : ptr_cur + 8'd1;
      end
    end
  end

  // RAM data is read-before-write, so the old slot content arrives with the registered byte.
  assign bus.out_data_o  = sel_ram_q ? bus.ram_rdata_i : data_q;
  assign bus.out_sync_o  = out_sync_q;
  assign bus.out_valid_o = out_valid_q;
  assign primed_o        = (fill_q == 12'(PRIME));
  assign sync_err_o      = sync_err_q;
  assign dbg_state_o     = DEBUG ? {1'b0, state_q} : 2'b00;

  if (SIMULATION) begin : g_sim
    a_addr_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      ram_access |-> (int'(bus.ram_addr_o) < TOTAL));
  end
endmodule

// File: tb/tb_dvbc_interleaver_ctrl.sv
// Randomized scoreboard bench for dvbc_interleaver_ctrl with a RAM model and a per-branch FIFO reference.
module tb_dvbc_interleaver_ctrl;
  localparam int IB    = 12;
  localparam int MD    = 17;
  localparam int AW    = 11;
  localparam int PRIME = IB * MD * (IB - 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       primed, sync_err;
  logic [1:0] dbg;
  logic       ram_clr;
  logic [7:0] mem [2048];
  logic [7:0] ram_q;

  always #5 clk = ~clk;

  dvbc_interleaver_ctrl_if #(.ADDR_W(AW)) bus ();

  dvbc_interleaver_ctrl #(
    .SIMULATION(1'b1), .DEBUG(1'b1), .I_BRANCH(IB), .M_DEPTH(MD), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .primed_o(primed), .sync_err_o(sync_err), .dbg_state_o(dbg)
  );

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else if (bus.ram_en_o) begin
      ram_q <= mem[bus.ram_addr_o];
      if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    end
  end
  assign bus.ram_rdata_i = ram_q;

  typedef struct packed { logic [7:0] d; logic s; } exp_t;
  exp_t       exp_q [$];
  logic [7:0] dl [IB][$];
  int         wcnt [IB];
  int         errors = 0, checks = 0;
  bit         mrun, err_pend, bp_mode, gap_mode, rand_data;
  int         mb, fill, pkt_pos, idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic int base_of(input int b);
    int s = 0;
    for (int j = 1; j < b; j++) s += MD * j;
    return s;
  endfunction

  task automatic model_reset();
    mrun = 0; mb = 0; fill = 0; err_pend = 0;
    for (int b = 0; b < IB; b++) begin
      wcnt[b] = 0;
      dl[b].delete();
      for (int j = 0; j < MD * b; j++) dl[b].push_back(8'h00);
    end
  endtask

  task automatic cycle_checks();
    chk("sync_err", 32'(sync_err), 32'(err_pend));
    err_pend = 0;
    chk("primed", 32'(primed), 32'(fill >= PRIME));
  endtask

  task automatic accept_byte(input logic [7:0] d, input logic s);
    int   br;
    exp_t e;
    chk("dbg_state", 32'(dbg), 32'(mrun));
    if (!mrun) begin
      chk("hunt_ready", 32'(bus.in_ready_o), 32'(1));
      if (!s) begin
        chk("hunt_no_ram", 32'(bus.ram_en_o), 32'(0));
        return;
      end
      mrun = 1; fill = 0; mb = 0;
    end
    br       = s ? 0 : mb;
    err_pend = s && (mb != 0);
    if (fill < PRIME) fill++;
    if (br == 0) begin
      chk("b0_no_ram", 32'(bus.ram_en_o), 32'(0));
      e.d = d;
    end else begin
      chk("ram_en", 32'(bus.ram_en_o), 32'(1));
      chk("ram_we", 32'(bus.ram_we_o), 32'(1));
      chk("ram_addr", 32'(bus.ram_addr_o), 32'(base_of(br) + wcnt[br] % (MD * br)));
      chk("ram_wdata", 32'(bus.ram_wdata_o), 32'(d));
      wcnt[br]++;
      e.d = dl[br].pop_front();
      dl[br].push_back(d);
    end
    e.s = s;
    exp_q.push_back(e);
    mb = (br == IB - 1) ? 0 : br + 1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int tries = 0;
    bit done  = 0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid_i  = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data_i   = d;
      bus.in_sync_i   = s;
      bus.out_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cycle_checks();
      if (bus.in_valid_i && bus.in_ready_o) begin
        accept_byte(d, s);
        done = 1;
      end else begin
        chk("ram_idle", 32'(bus.ram_en_o), 32'(0));
      end
      tries++;
      if (!done && tries >= 64) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no accept in %0d cycles expected accept", tries);
        done = 1;
      end
    end
  endtask

  task automatic next_stream_byte();
    logic s;
    s = (pkt_pos == 0);
    send_byte(rand_data ? 8'($urandom) : 8'(idx), s);
    idx++;
    pkt_pos = (pkt_pos + 1) % 204;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ram_clr = 1'b1;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'(0));
    chk("rst_out_sync", 32'(bus.out_sync_o), 32'(0));
    chk("rst_out_data", 32'(bus.out_data_o), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'(1));
    chk("rst_ram_en", 32'(bus.ram_en_o), 32'(0));
    chk("rst_ram_addr", 32'(bus.ram_addr_o), 32'(0));
    chk("rst_ram_wdata", 32'(bus.ram_wdata_o), 32'(0));
    chk("rst_primed", 32'(primed), 32'(0));
    chk("rst_sync_err", 32'(sync_err), 32'(0));
    chk("rst_dbg", 32'(dbg), 32'(0));
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ram_clr = 1'b0;
  endtask

  // Output scoreboard: pops on every handshake, checks stability across stalls.
  initial begin
    exp_t       e;
    bit         pst = 0;
    logic [7:0] pd;
    logic       ps;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pst = 0;
        continue;
      end
      if (pst) begin
        chk("stall_valid", 32'(bus.out_valid_o), 32'(1));
        chk("stall_data", 32'(bus.out_data_o), 32'(pd));
        chk("stall_sync", 32'(bus.out_sync_o), 32'(ps));
      end
      pst = 0;
      if (bus.out_valid_o) begin
        if (!bus.out_ready_i) begin
          pst = 1; pd = bus.out_data_o; ps = bus.out_sync_o;
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data_o), 32'(e.d));
          chk("out_sync", 32'(bus.out_sync_o), 32'(e.s));
        end
      end
    end
  end

  initial begin
    bus.in_valid_i = 1'b0; bus.in_data_i = 8'h00; bus.in_sync_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bp_mode = 0; gap_mode = 0; rand_data = 0;
    model_reset();
    do_reset();

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h47, 1'b1);
    pkt_pos = 1; idx = 1;
    for (int n = 0; n < 12 * 204 - 1; n++) next_stream_byte();

    while (mb != 5) next_stream_byte();
    send_byte(8'hB8, 1'b1);
    pkt_pos = 1;
    for (int n = 0; n < 300; n++) next_stream_byte();

    while (pkt_pos != 0) next_stream_byte();
    bp_mode = 1; gap_mode = 1; rand_data = 1;
    for (int n = 0; n < 3 * 204; n++) begin
      if (n == 204 + 100) begin
        do_reset();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        pkt_pos = 0;
      end
      next_stream_byte();
    end

    @(negedge clk);
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      #1;
      cycle_checks();
      @(negedge clk);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dvbc_interleaver_ctrl.md
# dvbc_interleaver_ctrl

Sequencing controller for the DVB-C convolutional (Forney) interleaver, I = 12 branches, M = 17 bytes per delay unit (ETSI EN 300429).
- Sits between the Reed-Solomon encoder output and the byte-to-symbol mapper.
- Hunts for the first sync byte, then rotates a branch commutator over the input byte stream.
- Keeps one circular pointer per branch and drives a single shared synchronous RAM that holds all eleven delay lines (branch 0 bypasses).

## Interface
- SIMULATION, 0, enables simulation-only checks.
- DEBUG, 0, exposes the internal state on dbg_state_o when 1; dbg_state_o is tied 0 otherwise.
- I_BRANCH, 12, number of interleaver branches.
- M_DEPTH, 17, delay increment per branch, in bytes.
- ADDR_W, 11, RAM address width; must cover M_DEPTH·I_BRANCH·(I_BRANCH−1)/2 = 1122 entries.
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- in_data_i  in  8  input byte.
- in_sync_i  in  1  marks the first byte of a 204-byte packet.
- in_valid_i  in  1  input handshake.
- in_ready_o  out  1  input handshake.
- out_data_o  out  8  interleaved byte.
- out_sync_o  out  1  sync marker aligned with out_data_o.
- out_valid_o  out  1  output handshake.
- out_ready_i  in  1  output handshake.
- ram_en_o  out  1  RAM access strobe (read and write in the same cycle).
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  8  RAM write data.
- ram_rdata_i  in  8  RAM read data; valid 1 cycle after ram_en_o; held while ram_en_o = 0; read-before-write.
- primed_o  out  1  all delay lines hold stream data.
- sync_err_o  out  1  one-cycle pulse on a misplaced sync byte.
- dbg_state_o  out  2  FSM state.

## Operation
- FSM states: HUNT = 0, RUN = 1.
  - Reset state is HUNT.
  - HUNT: in_ready_o = 1. Non-sync bytes are accepted and dropped; there is no RAM access and no output.
  - HUNT → RUN on an accepted byte with in_sync_i = 1. That byte is processed as branch 0.
- Accept condition: in_valid_i & in_ready_o.
  - In RUN, in_ready_o = out_ready_i | ~out_valid_o (one-stage output register).
- Branch counter b, range 0..I_BRANCH−1.
  - Increments on every byte accepted in RUN and wraps 11 → 0.
  - A byte accepted with in_sync_i forces b = 0 for that byte; the next byte is branch 1.
- Per accepted byte in branch b:
  - b = 0: no RAM access; the byte goes to the output register directly.
  - b > 0: ram_en_o = ram_we_o = 1, ram_addr_o = base[b] + ptr[b], ram_wdata_o = in_data_i. The old content read back is the output byte.
  - ptr[b] then increments modulo M_DEPTH·b.
- base[b] = M_DEPTH·b·(b−1)/2: base[1] = 0, base[2] = 17, base[11] = 935. The last address is 1121.
- ptr[b] is 8 bits wide; its maximum value is 186.
- Sync error: in RUN, an accepted byte with in_sync_i = 1 while b ≠ 0.
  - sync_err_o pulses for 1 cycle.
  - The byte is treated as branch 0.
  - Pointers are kept; the FSM stays in RUN.
- Fill counter (12-bit):
  - Cleared on reset and on entry to RUN.
  - Counts accepted bytes in RUN and saturates.
  - primed_o = 1 once it reaches I_BRANCH·M_DEPTH·(I_BRANCH−1) = 2244.
  - Before primed_o, outputs from branches 1..11 carry undefined RAM content.

## Timing
- Reset values:
  - in_ready_o = 1 (HUNT).
  - out_valid_o, out_sync_o, ram_en_o, ram_we_o, primed_o, sync_err_o = 0.
  - out_data_o, ram_addr_o, ram_wdata_o = 0.
  - All ptr[b] = 0, b = 0, and the fill counter = 0.
- Input-to-output latency: 1 cycle. The byte accepted at cycle t is presented with out_valid_o = 1 at t+1.
  - The output mux select (branch 0 vs RAM) is registered alongside the sync flag.
  - out_data_o takes the registered byte for branch 0, or ram_rdata_i for branches 1..11.
- Stall: out_valid_o & ~out_ready_i holds out_data_o and out_sync_o stable and drops in_ready_o.
  - No RAM access occurs during a stall, so ram_rdata_i stays valid.
- Simultaneous output pop and input accept sustains 1 byte per cycle.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). The next accepted sync byte restarts the stream.
- Interleaver delay: a byte in branch b emerges b·M_DEPTH·I_BRANCH accepted bytes later. Branch 1 gives 204.

## Test plan
- Reset, then feed 0x11 and 0x22 without sync, then 0x47 with sync -> no output for the first two; 0x47 appears with out_sync_o = 1 one cycle later; no RAM strobe for it.
- Continuous 204-byte packets, payload = index mod 256, out_ready_i = 1 -> accepted byte 1 is written to RAM address 0 and reappears as the output of accepted byte 205. Addresses cycle 0..16 for branch 1 and 935..1121 for branch 11.
- Count bytes from lock -> primed_o rises on the 2244th accepted byte and stays high.
- Sync byte injected at branch 5 -> sync_err_o pulses once; the next byte uses branch 1; stream continues without a return to HUNT.
- Random out_ready_i backpressure over 3 packets -> output sequence identical to the no-stall run; out_data_o stable during every stall.
- Assert rst_n_i at byte 100 of packet 2 -> outputs clear asynchronously; FSM returns to HUNT; the next sync relocks with ptr[1] = 0.
